// File: rtl/partoserial_tx_pkg.sv
// partoserial_tx_pkg: shared character constants and FSM encoding for the serial transmit path
package partoserial_tx_pkg;
  localparam int CHAR_BITS = 8;
  localparam logic [CHAR_BITS-1:0] BC_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_DATA} state_t;
endpackage

// File: rtl/partoserial_tx_fifo.sv
// partoserial_tx_fifo: synchronous FIFO with registered level; pushes are refused while full
module partoserial_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic wr, rd;
  always_comb begin
    full = level_q == (AW+1)'(DEPTH);
    empty = level_q == '0;
    wr = push && !full;
    rd = pop && !empty;
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d = level_q + (AW+1)'(wr) - (AW+1)'(rd);
    dout = mem_q[rd_ptr_q];
    level = level_q;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
endmodule

// File: rtl/partoserial_tx.sv
// partoserial_tx: buffers parallel bytes and serialises them MSB-first, filling gaps with BC
module partoserial_tx import partoserial_tx_pkg::*; #(
  parameter int                   DEPTH   = 4,
  parameter int                   SYNC_BC = 6,
  parameter logic [CHAR_BITS-1:0] BC_CHAR = BC_DEFAULT
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  input  logic [CHAR_BITS-1:0]   data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   data_out,
  output logic                   byte_sync,
  output logic                   idle_out,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int BW = $clog2(CHAR_BITS);
  localparam int SW = $clog2(SYNC_BC + 1);
  state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic [CHAR_BITS-1:0] shreg_q, shreg_d, head;
  logic idle_q, idle_d;
  logic load, sync_done, in_sync, pop, full, empty;
  partoserial_tx_fifo #(.DEPTH(DEPTH), .WIDTH(CHAR_BITS)) u_fifo (
    .clk(clk_32f),
    .rst(reset),
    .push(valid_in),
    .pop(pop),
    .din(data_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk_32f)
    if (reset) begin
      state_q <= ST_SYNC;
      bit_cnt_q <= '0;
      sync_cnt_q <= SW'(1);
      shreg_q <= BC_CHAR;
      idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      shreg_q <= shreg_d;
      idle_q <= idle_d;
    end
  // SYNC holds until SYNC_BC characters went out; after that every state follows FIFO occupancy
  always_comb begin
    load = bit_cnt_q == '1;
    sync_done = sync_cnt_q == SW'(SYNC_BC);
    in_sync = state_q == ST_SYNC && !sync_done;
    state_d = (!load || in_sync) ? state_q : (empty ? ST_IDLE : ST_DATA);
  end
  always_comb begin
    pop = load && !empty && !in_sync;
    shreg_d = load ? (pop ? head : BC_CHAR) : {shreg_q[CHAR_BITS-2:0], 1'b0};
    idle_d = load ? !pop : idle_q;
    bit_cnt_d = bit_cnt_q + BW'(1);
    sync_cnt_d = (load && in_sync) ? sync_cnt_q + SW'(1) : sync_cnt_q;
    data_out = shreg_q[CHAR_BITS-1];
    byte_sync = bit_cnt_q == '0;
    idle_out = idle_q;
    ready_out = !full;
  end
endmodule

// File: tb/tb_partoserial_tx.sv
// tb_partoserial_tx: randomized and directed checks against a character-level stream model
module tb_partoserial_tx;
  localparam int DEPTH = 4;
  localparam int SYNC_BC = 6;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [7:0] BC = 8'hBC;
  logic clk_32f = 0, reset = 1, valid_in = 0;
  logic [7:0] data_in = 0;
  logic ready_out, data_out, byte_sync, idle_out;
  logic [LW-1:0] fifo_level;
  int errors = 0, checks = 0;
  int m_c;
  logic [7:0] m_char;
  logic m_idle;
  logic [7:0] m_q[$], acc_q[$];

  partoserial_tx #(.DEPTH(DEPTH), .SYNC_BC(SYNC_BC), .BC_CHAR(BC)) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .data_out(data_out),
    .byte_sync(byte_sync),
    .idle_out(idle_out),
    .fifo_level(fifo_level)
  );

  always #5 clk_32f = ~clk_32f;

  // Character k occupies cycles 8k..8k+7; its content is chosen on cycle 8k-1 from bytes
  // accepted strictly before that cycle, and only once the SYNC_BC burst is complete.
  function automatic logic [LW+3:0] expv();
    int b = m_c % 8;
    return {m_q.size() < DEPTH, LW'(m_q.size()), m_char[7-b], b == 0, m_idle};
  endfunction

  function automatic logic [LW+3:0] obs();
    return {ready_out, fifo_level, data_out, byte_sync, idle_out};
  endfunction

  function automatic void model_reset();
    m_c = 0;
    m_q.delete();
    acc_q.delete();
    m_char = BC;
    m_idle = 1;
  endfunction

  task automatic tick(input logic v, input logic [7:0] d);
    logic acc;
    valid_in = v;
    data_in = d;
    acc = v && m_q.size() < DEPTH;
    if (m_c % 8 == 7) begin
      if ((m_c + 1) / 8 >= SYNC_BC && m_q.size() != 0) begin
        m_char = m_q.pop_front();
        m_idle = 0;
      end else begin
        m_char = BC;
        m_idle = 1;
      end
    end
    if (acc) begin
      m_q.push_back(d);
      acc_q.push_back(d);
    end
    m_c++;
    @(negedge clk_32f);
  endtask

  task automatic do_reset();
    reset = 1;
    valid_in = 0;
    repeat (2) @(negedge clk_32f);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    valid_in = 1;
    data_in = 8'h77;
    repeat (2) @(negedge clk_32f);
    if (obs() !== {1'b1, LW'(0), 3'b111}) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs(), {1'b1, LW'(0), 3'b111});
    end
    checks++;
    valid_in = 0;
    reset = 0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      tick(0, 8'h00);
    end
  endtask

  task automatic test_idle_stream();
    logic [7:0] ch = 0;
    int syncs = 0;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL idle_stream cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      ch = {ch[6:0], data_out};
      syncs += int'(byte_sync);
      if (m_c % 8 == 7) begin
        if (ch !== BC || idle_out !== 1'b1) begin
          errors++;
          $display("FAIL idle_char cyc=%0d got=%h/%b exp=bc/1", m_c, ch, idle_out);
        end
        checks++;
      end
      tick(0, 8'h00);
    end
    if (syncs != 10) begin
      errors++;
      $display("FAIL idle_sync_count got=%0d exp=10", syncs);
    end
    checks++;
  endtask

  task automatic test_sync_write();
    logic [7:0] ch = 0;
    do_reset();
    while (m_c < 64) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL sync_write cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      if (m_c == 40 || m_c == 48 || m_c == 56) begin
        if (idle_out !== (m_c != 48)) begin
          errors++;
          $display("FAIL sync_write_idle cyc=%0d got=%b exp=%b", m_c, idle_out, m_c != 48);
        end
        checks++;
      end
      if (m_c >= 48 && m_c < 56) ch = {ch[6:0], data_out};
      tick(m_c == 3, 8'hA5);
    end
    if (ch !== 8'hA5) begin
      errors++;
      $display("FAIL sync_write_byte got=%h exp=a5", ch);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [31:0] cap = 0;
    logic [7:0] ch = 0;
    do_reset();
    while (m_c < 112) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      if (m_c == 68) begin
        if (ready_out !== 1'b0 || fifo_level !== LW'(4)) begin
          errors++;
          $display("FAIL b2b_full got=%b/%0d exp=0/4", ready_out, fifo_level);
        end
        checks++;
      end
      if (m_c >= 72 && m_c < 104) cap = {cap[30:0], data_out};
      if (m_c >= 104) ch = {ch[6:0], data_out};
      if (m_c >= 64 && m_c < 69) tick(1, vals[m_c-64]);
      else tick(0, 8'h00);
    end
    if (cap !== 32'h11223344 || ch !== BC) begin
      errors++;
      $display("FAIL b2b_stream got=%h,%h exp=11223344,bc", cap, ch);
    end
    checks++;
  endtask

  task automatic test_write_at_load();
    logic [7:0] ch = 0;
    do_reset();
    while (m_c < 80) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL write_at_load cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      if (m_c == 64 || m_c == 72) begin
        if (idle_out !== (m_c == 64) || byte_sync !== 1'b1) begin
          errors++;
          $display("FAIL wal_idle cyc=%0d got=%b%b exp=%b1", m_c, idle_out, byte_sync, m_c == 64);
        end
        checks++;
      end
      if (m_c >= 72) ch = {ch[6:0], data_out};
      tick(m_c == 63, 8'h5A);
    end
    if (ch !== 8'h5A) begin
      errors++;
      $display("FAIL wal_byte got=%h exp=5a", ch);
    end
    checks++;
  endtask

  task automatic test_reset_mid_char();
    do_reset();
    while (m_c < 51) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      tick(m_c < 3, 8'(8'hC0 + m_c));
    end
    if (fifo_level !== LW'(2) || idle_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_queued got=%0d/%b exp=2/0", fifo_level, idle_out);
    end
    checks++;
    reset = 1;
    valid_in = 0;
    @(negedge clk_32f);
    if ({fifo_level, data_out, byte_sync, idle_out} !== {LW'(0), 3'b111}) begin
      errors++;
      $display("FAIL mid_reset_state got=%b exp=%b", {fifo_level, data_out, byte_sync, idle_out}, {LW'(0), 3'b111});
    end
    checks++;
    reset = 0;
    model_reset();
    for (int i = 0; i < 120; i++) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL mid_reset_post cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      tick(0, 8'h00);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rx_sh = 0, d;
    logic [7:0] rx_q[$];
    int rx_n = 0, guard = 0, drain = 0;
    do_reset();
    while ((acc_q.size() < 200 && guard < 20000) || drain < 64) begin
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL loopback cyc=%0d got=%b exp=%b", m_c, obs(), expv());
      end
      checks++;
      if (byte_sync) rx_n = 0;
      rx_sh = {rx_sh[6:0], data_out};
      rx_n++;
      if (rx_n == 8 && rx_sh != BC) rx_q.push_back(rx_sh);
      d = 8'($urandom);
      if (d == BC) d = 8'h3C;
      if (acc_q.size() < 200 && guard < 20000) begin
        tick($urandom_range(0, 3) != 0, d);
        guard++;
      end else begin
        tick(0, 8'h00);
        drain++;
      end
    end
    if (acc_q.size() != 200 || rx_q.size() != acc_q.size()) begin
      errors++;
      $display("FAIL loopback_count got=%0d exp=%0d (accepted %0d of 200)", rx_q.size(), acc_q.size(), acc_q.size());
    end
    checks++;
    for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
      if (rx_q[i] !== acc_q[i]) begin
        errors++;
        $display("FAIL loopback_byte idx=%0d got=%h exp=%h", i, rx_q[i], acc_q[i]);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_stream();
    test_sync_write();
    test_back_to_back();
    test_write_at_load();
    test_reset_mid_char();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end
endmodule
